// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port 0 normally wins, loader/debug port 1 is
// guaranteed a grant after STARVE_MAX consecutive port-0 wins while it waits.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_in,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic              p0_sign,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic [31:0]       p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic              p1_sign,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic [31:0]       p1_rdata,

    output logic              dm_ena,
    output logic              dm_r,
    output logic              dm_w,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_data_in,
    input  logic [31:0]       dm_data_out,

    output logic              sb_flag,
    output logic              sh_flag,
    output logic              sw_flag,
    output logic              lb_flag,
    output logic              lh_flag,
    output logic              lbu_flag,
    output logic              lhu_flag,
    output logic              lw_flag
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sign;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              port;
    } xact_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    xact_t            xact_q, xact_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      p0_rdata_q, p0_rdata_d;
    logic [31:0]      p1_rdata_q, p1_rdata_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             ena_q, ena_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [7:0]       flags_q, flags_d;
    logic             grant_p1;

    // Flag vector order: {sb, sh, sw, lb, lh, lbu, lhu, lw}
    function automatic logic [7:0] decode_flags(input logic we, input logic [1:0] size,
                                                input logic sign);
        logic [7:0] f;
        f = '0;
        if (we) begin
            case (size)
                2'b00:   f[7] = 1'b1;
                2'b01:   f[6] = 1'b1;
                default: f[5] = 1'b1;
            endcase
        end else begin
            case (size)
                2'b00:   if (sign) f[4] = 1'b1; else f[2] = 1'b1;
                2'b01:   if (sign) f[3] = 1'b1; else f[1] = 1'b1;
                default: f[0] = 1'b1;
            endcase
        end
        return f;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        xact_d     = xact_q;
        cnt_d      = cnt_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        ena_d      = 1'b0;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        flags_d    = '0;
        grant_p1   = p1_req && (!p0_req || (cnt_q == CNT_MAX));

        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = S_ACCESS;
                    if (grant_p1) begin
                        xact_d.we    = p1_we;
                        xact_d.size  = p1_size;
                        xact_d.sign  = p1_sign;
                        xact_d.addr  = p1_addr;
                        xact_d.wdata = p1_wdata;
                        xact_d.port  = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        xact_d.we    = p0_we;
                        xact_d.size  = p0_size;
                        xact_d.sign  = p0_sign;
                        xact_d.addr  = p0_addr;
                        xact_d.wdata = p0_wdata;
                        xact_d.port  = 1'b0;
                        if (p1_req && (cnt_q != CNT_MAX))
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                    ena_d   = 1'b1;
                    rd_d    = !xact_d.we;
                    wr_d    = xact_d.we;
                    flags_d = decode_flags(xact_d.we, xact_d.size, xact_d.sign);
                end
            end
            S_ACCESS: begin
                state_d = S_ACK;
                if (!xact_q.we) begin
                    if (xact_q.port) p1_rdata_d = dm_data_out;
                    else             p0_rdata_d = dm_data_out;
                end
                ack0_d = !xact_q.port;
                ack1_d = xact_q.port;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            xact_q     <= '0;
            cnt_q      <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            ena_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            xact_q     <= xact_d;
            cnt_q      <= cnt_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            ena_q      <= ena_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            flags_q    <= flags_d;
        end
    end

    assign p0_ack     = ack0_q;
    assign p1_ack     = ack1_q;
    assign p0_rdata   = p0_rdata_q;
    assign p1_rdata   = p1_rdata_q;
    assign dm_ena     = ena_q;
    assign dm_r       = rd_q;
    assign dm_w       = wr_q;
    assign dm_addr    = xact_q.addr;
    assign dm_data_in = xact_q.wdata;

    assign sb_flag  = flags_q[7];
    assign sh_flag  = flags_q[6];
    assign sw_flag  = flags_q[5];
    assign lb_flag  = flags_q[4];
    assign lh_flag  = flags_q[3];
    assign lbu_flag = flags_q[2];
    assign lhu_flag = flags_q[1];
    assign lw_flag  = flags_q[0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: store/load decode, latency, rdata capture,
// starvation-limited arbitration and reset during an access.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 7;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              p0_req, p0_we, p0_sign;
    logic [1:0]        p0_size;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata;
    logic              p0_ack;
    logic [31:0]       p0_rdata;
    logic              p1_req, p1_we, p1_sign;
    logic [1:0]        p1_size;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata;
    logic              p1_ack;
    logic [31:0]       p1_rdata;
    logic              dm_ena, dm_r, dm_w;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_data_in;
    logic [31:0]       dm_data_out;
    logic sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag;
    logic [7:0]        flags;

    int                total = 0;
    int                passed = 0;
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [31:0]       last_wr_data = '0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk_in(clk_in), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sign(p0_sign),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sign(p1_sign),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .dm_ena(dm_ena), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr),
        .dm_data_in(dm_data_in), .dm_data_out(dm_data_out),
        .sb_flag(sb_flag), .sh_flag(sh_flag), .sw_flag(sw_flag),
        .lb_flag(lb_flag), .lh_flag(lh_flag), .lbu_flag(lbu_flag),
        .lhu_flag(lhu_flag), .lw_flag(lw_flag)
    );

    always #5 clk_in = ~clk_in;

    assign flags = {sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag};

    // Stand-in DMEM write port: records every write the arbiter commits
    always @(posedge clk_in) begin
        if (dm_ena && dm_w) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= dm_addr;
            last_wr_data <= dm_data_in;
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    int wr_before;
    logic exp_p1;

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_size = 0; p0_sign = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_sign = 0; p1_addr = '0; p1_wdata = '0;
        dm_data_out = '0;
        tick; tick;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_ctl", 32'({dm_ena, dm_r, dm_w, p0_ack, p1_ack}), 32'h0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_addr", 32'(dm_addr), 32'h0);
        reset = 1'b0;
        tick;

        // p0 sw 0x04 <- DEADBEEF
        p0_req = 1; p0_we = 1; p0_size = 2'b10; p0_addr = 7'h04; p0_wdata = 32'hDEADBEEF;
        tick;
        chk("sw_ctl", 32'({dm_ena, dm_r, dm_w}), 32'b101);
        chk("sw_flags", 32'(flags), 32'b0010_0000);
        chk("sw_addr", 32'(dm_addr), 32'h04);
        chk("sw_data", dm_data_in, 32'hDEADBEEF);
        chk("sw_noack_yet", 32'(p0_ack), 32'h0);
        tick;
        p0_req = 0;
        chk("sw_ack", 32'({p0_ack, p1_ack}), 32'b10);
        chk("sw_idle_ctl", 32'({dm_ena, dm_w, flags}), 32'h0);
        chk("sw_mem_addr", 32'(last_wr_addr), 32'h04);
        chk("sw_mem_data", last_wr_data, 32'hDEADBEEF);
        chk("sw_hold_addr", 32'(dm_addr), 32'h04);
        tick;
        chk("sw_ack_pulse", 32'(p0_ack), 32'h0);

        // p1 lbu 0x05
        p1_req = 1; p1_we = 0; p1_size = 2'b00; p1_sign = 0; p1_addr = 7'h05;
        dm_data_out = 32'h000000EF;
        tick;
        chk("lbu_flags", 32'(flags), 32'b0000_0100);
        chk("lbu_ctl", 32'({dm_ena, dm_r, dm_w}), 32'b110);
        chk("lbu_addr", 32'(dm_addr), 32'h05);
        tick;
        p1_req = 0;
        chk("lbu_ack", 32'({p0_ack, p1_ack}), 32'b01);
        chk("lbu_p1_rdata", p1_rdata, 32'h000000EF);
        chk("lbu_p0_rdata", p0_rdata, 32'h0);
        tick;

        // p0 size 11 load -> lw only, sign ignored
        p0_req = 1; p0_we = 0; p0_size = 2'b11; p0_sign = 1; p0_addr = 7'h08;
        dm_data_out = 32'h12345678;
        tick;
        chk("lw11_flags", 32'(flags), 32'b0000_0001);
        tick;
        chk("lw11_p0_rdata", p0_rdata, 32'h12345678);
        chk("lw11_p1_hold", p1_rdata, 32'h000000EF);
        tick;

        // p0 lh (half, signed)
        p0_size = 2'b01; p0_sign = 1; p0_addr = 7'h0A; dm_data_out = 32'hFFFF8001;
        tick;
        chk("lh_flags", 32'(flags), 32'b0000_1000);
        tick;
        chk("lh_p0_rdata", p0_rdata, 32'hFFFF8001);
        tick;

        // p0 sb with sign=1 -> sb only; store leaves p0_rdata alone
        p0_we = 1; p0_size = 2'b00; p0_sign = 1; p0_addr = 7'h0B; p0_wdata = 32'h000000A5;
        dm_data_out = 32'hCAFECAFE;
        tick;
        chk("sb_flags", 32'(flags), 32'b1000_0000);
        tick;
        p0_req = 0;
        chk("sb_rdata_hold", p0_rdata, 32'hFFFF8001);
        tick;

        // Both ports requesting continuously: p0 x4, p1, p0 x4, p1
        p0_req = 1; p0_we = 1; p0_size = 2'b10; p0_addr = 7'h10; p0_wdata = 32'h0;
        p1_req = 1; p1_we = 1; p1_size = 2'b10; p1_addr = 7'h20; p1_wdata = 32'h1;
        for (int i = 0; i < 10; i++) begin
            exp_p1 = (i == 4) || (i == 9);
            tick;
            chk($sformatf("arb_addr_%0d", i), 32'(dm_addr), exp_p1 ? 32'h20 : 32'h10);
            tick;
            chk($sformatf("arb_ack_%0d", i), 32'({p0_ack, p1_ack}), exp_p1 ? 32'b01 : 32'b10);
            tick;
        end
        p0_req = 0; p1_req = 0;
        tick;

        // Reset asserted mid-ACCESS of a store
        p0_req = 1; p0_we = 1; p0_size = 2'b10; p0_addr = 7'h30; p0_wdata = 32'h55555555;
        tick;
        chk("rstmid_w_before", 32'(dm_w), 32'h1);
        wr_before = wr_count;
        #2 reset = 1'b1;
        #1;
        chk("rstmid_w_drop", 32'({dm_ena, dm_w, flags}), 32'h0);
        tick;
        chk("rstmid_no_write", 32'(wr_count), 32'(wr_before));
        chk("rstmid_no_ack", 32'({p0_ack, p1_ack}), 32'h0);
        chk("rstmid_rdata_clr", p1_rdata, 32'h0);
        p0_req = 0;
        reset = 1'b0;
        tick;
        chk("rstmid_idle", 32'({dm_ena, p0_ack, p1_ack}), 32'h0);
        tick;
        chk("rstmid_no_ack2", 32'({p0_ack, p1_ack}), 32'h0);

        // Fresh transaction after reset: p1 lhu
        p1_req = 1; p1_we = 0; p1_size = 2'b01; p1_sign = 0; p1_addr = 7'h12;
        dm_data_out = 32'h0000BEEF;
        tick;
        chk("lhu_flags", 32'(flags), 32'b0000_0010);
        tick;
        p1_req = 0;
        chk("lhu_ack", 32'({p0_ack, p1_ack}), 32'b01);
        chk("lhu_p1_rdata", p1_rdata, 32'h0000BEEF);
        tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: DMEM word/byte address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4: number of consecutive port-0 wins tolerated while port 1 waits.
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port p0_req  input  1  CPU port request, held until p0_ack.
REQ-006 SHALL have port p0_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port p0_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port p0_sign  input  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
REQ-009 SHALL have port p0_addr  input  ADDR_W  DMEM-relative address.
REQ-010 SHALL have port p0_wdata  input  32  store data.
REQ-011 SHALL have port p0_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port p0_rdata  output  32  load data, valid in p0_ack cycle, held until next p0 load completes.
REQ-013 SHALL have ports p1_req/p1_we/p1_size/p1_sign/p1_addr/p1_wdata/p1_ack/p1_rdata  same directions/widths  second (loader/debug) port, identical semantics.
REQ-014 SHALL have port dm_ena  output  1  DMEM enable.
REQ-015 SHALL have port dm_r  output  1  DMEM read.
REQ-016 SHALL have port dm_w  output  1  DMEM write (DMEM writes on clk_in edge).
REQ-017 SHALL have port dm_addr  output  ADDR_W  DMEM address.
REQ-018 SHALL have port dm_data_in  output  32  DMEM write data.
REQ-019 SHALL have port dm_data_out  input  32  DMEM asynchronous read data (already size/sign processed).
REQ-020 SHALL have ports sb_flag, sh_flag, sw_flag  output  1 each  store size flags.
REQ-021 SHALL have ports lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  output  1 each  load size/sign flags.

Function
REQ-022 SHALL implement FSM IDLE -> ACCESS -> ACK -> IDLE; ACCESS and ACK always last exactly one cycle.
REQ-023 IDLE: if any req high, SHALL select winner, latch its we/size/sign/addr/wdata and port id, go ACCESS; else stay IDLE.
REQ-024 Winner: port 0 if p0_req, unless p1_req high and starve counter == STARVE_MAX, then port 1; port 1 if only p1_req.
REQ-025 Starve counter (width to hold STARVE_MAX) SHALL increment, saturating at STARVE_MAX, on each IDLE grant to port 0 while p1_req high; cleared on any grant to port 1.
REQ-026 ACCESS: dm_addr/dm_data_in from latched fields; dm_w = latched we, dm_r = !latched we, dm_ena = 1; exactly one flag high per latched we/size/sign; sign ignored for stores, word loads use lw_flag.
REQ-027 Outside ACCESS: dm_ena, dm_r, dm_w and all eight flags SHALL be 0; dm_addr/dm_data_in hold latched values.
REQ-028 On the ACCESS->ACK edge, for a load, the winning port's rdata register SHALL capture dm_data_out; the other port's rdata is unchanged.
REQ-029 ACK: winner's ack = 1 for exactly this cycle, other ack = 0; reqs are ignored in ACK.
REQ-030 Latency: req sampled high at IDLE edge k -> ACCESS cycle k+1 -> ack cycle k+2; max throughput one transaction per 3 cycles.
REQ-031 Requests dropped before ack are undefined usage; arbiter SHALL still complete the latched transaction and pulse ack.
REQ-032 No alignment checking; address bits pass unmodified to DMEM.

Reset
REQ-033 reset high SHALL immediately (asynchronously) force IDLE, starve counter 0, latched fields 0, p0_rdata = p1_rdata = 0, all acks, dm_ena/dm_r/dm_w and flags 0.
REQ-034 reset asserted during ACCESS SHALL drop dm_w before the next edge, so no DMEM write occurs and no ack is issued.

Verification
REQ-035 p0 sw addr 0x04 data 0xDEADBEEF: ACCESS cycle dm_w=1, sw_flag=1, dm_addr=0x04; p0_ack two cycles after req edge.
REQ-036 p1 lbu addr 0x05 with dm_data_out=0x000000EF: lbu_flag=1 in ACCESS; p1_rdata=0x000000EF with p1_ack.
REQ-037 Both req held continuously, STARVE_MAX=4: grant order p0,p0,p0,p0,p1,p0,...; counter returns to 0 after p1 grant.
REQ-038 p0_size=11, we=0: lw_flag=1 only; p0_size=01, sign=1: lh_flag=1 only.
REQ-039 reset pulsed mid-ACCESS of a store: dm_w falls same cycle, DMEM contents unchanged, no ack, FSM in IDLE after release.
